// File: rtl/ram_loader.sv
// Boot-time RAM image loader: streams load_len bytes into RAM, then verifies a
// trailing checksum byte before releasing the processor hold.
module ram_loader #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   len;
  logic [ADDR_W-1:0]   count;
  logic [7:0]          sum;
  logic [7:0]          csum;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                xfer;
  logic                timeout;
  logic                last_byte;

  // in_ready is registered and tracks the LOAD/CHECK states exactly
  assign xfer      = in_valid & in_ready;
  assign timeout   = (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign last_byte = (count == len - 1'b1);
  assign csum      = sum + in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_next = (load_len != '0) ? LOAD : ERR;
      end
      LOAD: begin
        if (timeout)                state_next = ERR;
        else if (xfer && last_byte) state_next = CHECK;
      end
      CHECK: begin
        if (timeout)   state_next = ERR;
        else if (xfer) state_next = (csum == 8'd0) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len      <= '0;
      count    <= '0;
      sum      <= '0;
      idle_cnt <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      in_ready <= (state_next == LOAD) || (state_next == CHECK);
      cpu_hold <= (state_next != DONE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
      case (state)
        IDLE, DONE, ERR: begin
          if (start && load_len != '0) begin
            len      <= load_len;
            count    <= '0;
            sum      <= '0;
            idle_cnt <= '0;
          end
        end
        LOAD: begin
          if (!timeout) begin
            if (xfer) begin
              ram_addr <= count;
              ram_data <= in_data;
              ram_we   <= 1'b1;
              sum      <= csum;
              count    <= count + 1'b1;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (!timeout) begin
            if (xfer) idle_cnt <= '0;
            else      idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed/randomized bench for ram_loader: a byte-stream model predicts the
// RAM writes, their one-cycle latency and the final done/error status.
module tb_ram_loader;

  localparam int AW = 15;
  localparam int TO = 1023;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] load_len = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_we;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  int img[$];

  ram_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: samples 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (ram_we === 1'b1) begin
      w_addr.push_back(int'(ram_addr));
      w_data.push_back(int'(ram_data));
      w_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(int len);
    start = 1'b1;
    load_len = AW'(len);
    tick();
    start = 1'b0;
  endtask

  // Offers one byte until accepted; xc is the monitor cycle before the accepting edge.
  task automatic send(int b, output int xc);
    in_valid = 1'b1;
    in_data = 8'(b);
    xc = -1;
    for (int k = 0; k < 64; k++) begin
      if (in_ready === 1'b1) begin
        xc = cyc;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (xc < 0) chk("send_ready", int'(in_ready), 1);
  endtask

  // Loads img (len bytes) plus a checksum byte; ck<0 means the correct checksum,
  // ck>=256 means a random wrong one. gap<0 gives random idle gaps.
  task automatic run_load(string tag, int gap, int ck);
    int len, s, good, base, xc, g, exp_ok;
    int xcs[$];
    len = img.size();
    s = 0;
    foreach (img[i]) s += img[i];
    good = (256 - (s % 256)) % 256;
    if (ck < 0) ck = good;
    else if (ck >= 256) ck = (good + int'($urandom_range(1, 255))) % 256;
    exp_ok = ((s + ck) % 256 == 0) ? 1 : 0;
    base = w_addr.size();
    pulse_start(len);
    for (int i = 0; i <= len; i++) begin
      send((i < len) ? img[i] : ck, xc);
      xcs.push_back(xc);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (i < len) repeat (g) tick();
    end
    chk({tag, "_done"}, int'(done), exp_ok);
    chk({tag, "_error"}, int'(error), 1 - exp_ok);
    chk({tag, "_hold"}, int'(cpu_hold), 1 - exp_ok);
    chk({tag, "_ready"}, int'(in_ready), 0);
    chk({tag, "_nwr"}, w_addr.size() - base, len);
    for (int i = 0; i < len && base + i < w_addr.size(); i++) begin
      chk({tag, "_addr"}, w_addr[base+i], i);
      chk({tag, "_data"}, w_data[base+i], img[i]);
      chk({tag, "_lat"}, w_cyc[base+i], xcs[i] + 1);
    end
    $display("load %s len=%0d ck=%0h expect_done=%0d done=%0d error=%0d", tag, len, ck, exp_ok, done, error);
  endtask

  initial begin
    int xc, base, n;

    // Reset state
    tick();
    tick();
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_hold", int'(cpu_hold), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_data", int'(ram_data), 0);
    rst_n = 1'b1;
    tick();
    $display("reset checked");

    // Known image, good then bad checksum
    img = '{8'h01, 8'h02, 8'h03};
    run_load("img3_good", 0, 8'hFA);
    run_load("img3_bad", 0, 8'hFB);

    // Two bytes with in_valid toggling every cycle
    img = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
    run_load("toggle", 1, -1);

    // Random lengths, data, gaps and checksum correctness
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 8));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(int'($urandom_range(0, 255)));
      run_load("rand", -1, ($urandom_range(0, 1) == 1) ? -1 : 256);
    end

    // Idle timeout: byte offered on the timeout cycle is dropped
    base = w_addr.size();
    pulse_start(4);
    send(int'($urandom_range(0, 255)), xc);
    repeat (TO - 1) tick();
    chk("to_before_ready", int'(in_ready), 1);
    chk("to_before_error", int'(error), 0);
    in_valid = 1'b1;
    in_data = 8'($urandom_range(0, 255));
    tick();
    in_valid = 1'b0;
    chk("to_error", int'(error), 1);
    chk("to_ready", int'(in_ready), 0);
    chk("to_done", int'(done), 0);
    chk("to_nwr", w_addr.size() - base, 1);
    $display("timeout error=%0d writes=%0d", error, w_addr.size() - base);

    // Zero length from DONE, then a one-byte image
    img = '{8'h33};
    run_load("one_good", 0, -1);
    base = w_addr.size();
    pulse_start(0);
    chk("zlen_error", int'(error), 1);
    chk("zlen_done", int'(done), 0);
    chk("zlen_hold", int'(cpu_hold), 1);
    chk("zlen_ready", int'(in_ready), 0);
    chk("zlen_nwr", w_addr.size() - base, 0);
    $display("zero length error=%0d", error);
    img = '{8'h55};
    run_load("one_55", 0, 8'hAB);

    // Start ignored during LOAD, then reset mid-load
    base = w_addr.size();
    pulse_start(5);
    send(8'h11, xc);
    pulse_start(7);
    chk("mid_start_ready", int'(in_ready), 1);
    send(8'h22, xc);
    in_valid = 1'b1;
    in_data = 8'h33;
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("midrst_we", int'(ram_we), 0);
    chk("midrst_hold", int'(cpu_hold), 1);
    chk("midrst_ready", int'(in_ready), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_nwr", w_addr.size() - base, 2);
    if (w_addr.size() - base == 2) begin
      chk("midrst_addr1", w_addr[base+1], 1);
      chk("midrst_data1", w_data[base+1], 8'h22);
    end
    chk("midrst_idle_ready", int'(in_ready), 0);
    $display("mid-load reset writes=%0d", w_addr.size() - base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
